// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-port register file with write-to-read bypass and busy scoreboard
module regfile_mp_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 4,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*AW-1:0]     wr_addr,
    input  logic [NWR*XLEN-1:0]   wr_data,
    input  logic                  issue_en,
    input  logic [AW-1:0]         issue_addr,
    input  logic                  flush
);

    logic [XLEN-1:0]  rf [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;

    // Address exists in the file (only matters when NREGS is not a power of two)
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < 32'(NREGS));
    endfunction

    // Register 0 is hardwired when ZERO_REG is set
    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Storage update: later (higher-index) ports overwrite earlier ones on the same address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                rf[r] <= '0;
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && addr_ok(wr_addr[w*AW +: AW]) && !is_zero(wr_addr[w*AW +: AW])) begin
                    rf[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    // Next busy vector: writes clear, a new issue re-arms over a same-cycle write, flush wins over all
    always_comb begin
        busy_next = busy;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && addr_ok(wr_addr[w*AW +: AW])) begin
                busy_next[wr_addr[w*AW +: AW]] = 1'b0;
            end
        end
        if (issue_en && addr_ok(issue_addr)) begin
            busy_next[issue_addr] = 1'b1;
        end
        if (flush) begin
            busy_next = '0;
        end
        if (ZERO_REG != 0) begin
            busy_next[0] = 1'b0;
        end
    end

    // Busy scoreboard state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Combinational read ports with optional forwarding of same-cycle write data
    always_comb begin
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rv;
        logic            hit;
        ra      = '0;
        rv      = '0;
        hit     = 1'b0;
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            ra  = rd_addr[i*AW +: AW];
            rv  = '0;
            hit = 1'b0;
            if (!is_zero(ra) && addr_ok(ra)) begin
                rv = rf[ra];
                if (BYPASS != 0) begin
                    for (int w = 0; w < NWR; w++) begin
                        if (wr_en[w] && (wr_addr[w*AW +: AW] == ra)) begin
                            rv  = wr_data[w*XLEN +: XLEN];
                            hit = 1'b1;
                        end
                    end
                end
                rd_busy[i] = busy[ra] && !hit;
            end
            rd_data[i*XLEN +: XLEN] = rv;
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - scoreboard bench for regfile_mp_sb
module tb_regfile_mp_sb;

    logic         clk;
    logic         reset;

    logic [19:0]  a_rd_addr;
    logic [127:0] a_rd_data;
    logic [3:0]   a_rd_busy;
    logic [1:0]   a_wr_en;
    logic [9:0]   a_wr_addr;
    logic [63:0]  a_wr_data;
    logic         a_issue_en;
    logic [4:0]   a_issue_addr;
    logic         a_flush;

    logic [9:0]   b_rd_addr;
    logic [63:0]  b_rd_data;
    logic [1:0]   b_rd_busy;
    logic [1:0]   b_wr_en;
    logic [9:0]   b_wr_addr;
    logic [63:0]  b_wr_data;
    logic         b_issue_en;
    logic [4:0]   b_issue_addr;
    logic         b_flush;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        bit          inst;
        int          port;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];

    regfile_mp_sb u_a (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (a_rd_addr),
        .rd_data    (a_rd_data),
        .rd_busy    (a_rd_busy),
        .wr_en      (a_wr_en),
        .wr_addr    (a_wr_addr),
        .wr_data    (a_wr_data),
        .issue_en   (a_issue_en),
        .issue_addr (a_issue_addr),
        .flush      (a_flush)
    );

    regfile_mp_sb #(.NRD(2), .BYPASS(0)) u_b (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (b_rd_addr),
        .rd_data    (b_rd_data),
        .rd_busy    (b_rd_busy),
        .wr_en      (b_wr_en),
        .wr_addr    (b_wr_addr),
        .wr_data    (b_wr_data),
        .issue_en   (b_issue_en),
        .issue_addr (b_issue_addr),
        .flush      (b_flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        a_wr_en    = '0;
        a_issue_en = 1'b0;
        a_flush    = 1'b0;
        b_wr_en    = '0;
        b_issue_en = 1'b0;
        b_flush    = 1'b0;
    endtask

    task automatic a_wr(input int p, input logic [4:0] ad, input logic [31:0] d);
        a_wr_en[p]            = 1'b1;
        a_wr_addr[p*5 +: 5]   = ad;
        a_wr_data[p*32 +: 32] = d;
    endtask

    task automatic b_wr(input int p, input logic [4:0] ad, input logic [31:0] d);
        b_wr_en[p]            = 1'b1;
        b_wr_addr[p*5 +: 5]   = ad;
        b_wr_data[p*32 +: 32] = d;
    endtask

    task automatic a_rd(input int p, input logic [4:0] ad);
        a_rd_addr[p*5 +: 5] = ad;
    endtask

    task automatic b_rd(input int p, input logic [4:0] ad);
        b_rd_addr[p*5 +: 5] = ad;
    endtask

    task automatic expect_rd(input string nm, input bit inst, input int p,
                             input logic [31:0] d, input logic bz);
        exp_t e;
        e.name = nm;
        e.inst = inst;
        e.port = p;
        e.data = d;
        e.busy = bz;
        exp_q.push_back(e);
    endtask

    // Monitor: read outputs are settled mid-cycle, so every pending expectation is checked at the falling edge
    initial begin
        exp_t        e;
        logic [31:0] got_d;
        logic        got_b;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.inst) begin
                    got_d = b_rd_data[e.port*32 +: 32];
                    got_b = b_rd_busy[e.port];
                end else begin
                    got_d = a_rd_data[e.port*32 +: 32];
                    got_b = a_rd_busy[e.port];
                end
                checks++;
                if (got_d !== e.data) begin
                    errors++;
                    $display("FAIL %s data: got %h expected %h", e.name, got_d, e.data);
                end
                checks++;
                if (got_b !== e.busy) begin
                    errors++;
                    $display("FAIL %s busy: got %b expected %b", e.name, got_b, e.busy);
                end
            end
        end
    end

    initial begin
        reset        = 1'b1;
        a_rd_addr    = '0;
        a_wr_en      = '0;
        a_wr_addr    = '0;
        a_wr_data    = '0;
        a_issue_en   = 1'b0;
        a_issue_addr = '0;
        a_flush      = 1'b0;
        b_rd_addr    = '0;
        b_wr_en      = '0;
        b_wr_addr    = '0;
        b_wr_data    = '0;
        b_issue_en   = 1'b0;
        b_issue_addr = '0;
        b_flush      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        a_rd(0, 5'd1); a_rd(1, 5'd2); a_rd(2, 5'd3); a_rd(3, 5'd31);
        b_rd(0, 5'd1);
        expect_rd("rst_p0", 0, 0, 32'h0, 1'b0);
        expect_rd("rst_p1", 0, 1, 32'h0, 1'b0);
        expect_rd("rst_p2", 0, 2, 32'h0, 1'b0);
        expect_rd("rst_p3", 0, 3, 32'h0, 1'b0);
        expect_rd("rst_b0", 1, 0, 32'h0, 1'b0);

        // Write rf[5], issue 6, then assert reset mid-cycle
        next_cycle();
        a_wr(0, 5'd5, 32'hDEADBEEF); a_issue_en = 1'b1; a_issue_addr = 5'd6;
        a_rd(0, 5'd5);
        expect_rd("t1_bypass", 0, 0, 32'hDEADBEEF, 1'b0);
        next_cycle();
        a_rd(0, 5'd5); a_rd(1, 5'd6);
        expect_rd("t1_stored", 0, 0, 32'hDEADBEEF, 1'b0);
        expect_rd("t1_busy6", 0, 1, 32'h0, 1'b1);
        next_cycle();
        reset = 1'b1;
        a_wr(1, 5'd8, 32'h77); a_rd(2, 5'd8);
        expect_rd("t1_rst_r5", 0, 0, 32'h0, 1'b0);
        expect_rd("t1_rst_b6", 0, 1, 32'h0, 1'b0);
        expect_rd("t1_rst_byp", 0, 2, 32'h77, 1'b0);
        next_cycle();
        reset = 1'b0;
        expect_rd("t1_post_r8", 0, 2, 32'h0, 1'b0);

        // Same-address write on both ports: higher port wins
        next_cycle();
        a_wr(0, 5'd7, 32'h11); a_wr(1, 5'd7, 32'h22); a_rd(0, 5'd7);
        expect_rd("t2_bypass", 0, 0, 32'h22, 1'b0);
        next_cycle();
        expect_rd("t2_stored", 0, 0, 32'h22, 1'b0);

        // Register 0 is hardwired and never busy
        next_cycle();
        a_wr(0, 5'd0, 32'hFFFFFFFF); a_issue_en = 1'b1; a_issue_addr = 5'd0; a_rd(0, 5'd0);
        expect_rd("t3_same", 0, 0, 32'h0, 1'b0);
        next_cycle();
        expect_rd("t3_next", 0, 0, 32'h0, 1'b0);

        // Issue 9, stall, then resolve by bypassed write
        next_cycle();
        a_issue_en = 1'b1; a_issue_addr = 5'd9; a_rd(0, 5'd9);
        expect_rd("t4_issue_cyc", 0, 0, 32'h0, 1'b0);
        next_cycle();
        expect_rd("t4_busy", 0, 0, 32'h0, 1'b1);
        next_cycle();
        a_wr(1, 5'd9, 32'hABCD);
        expect_rd("t4_wr_cyc", 0, 0, 32'hABCD, 1'b0);
        next_cycle();
        expect_rd("t4_after", 0, 0, 32'hABCD, 1'b0);

        // Issue and write same register, then flush (flush also overrides an issue)
        next_cycle();
        a_issue_en = 1'b1; a_issue_addr = 5'd3; a_wr(0, 5'd3, 32'h55); a_rd(0, 5'd3);
        expect_rd("t5_same", 0, 0, 32'h55, 1'b0);
        next_cycle();
        a_flush = 1'b1; a_issue_en = 1'b1; a_issue_addr = 5'd10; a_rd(1, 5'd10);
        expect_rd("t5_busy3", 0, 0, 32'h55, 1'b1);
        expect_rd("t5_flush_cyc10", 0, 1, 32'h0, 1'b0);
        next_cycle();
        expect_rd("t5_flushed3", 0, 0, 32'h55, 1'b0);
        expect_rd("t5_flushed10", 0, 1, 32'h0, 1'b0);

        // No-bypass instance: reads see stored value only
        next_cycle();
        b_wr(0, 5'd12, 32'h44); b_rd(0, 5'd12);
        expect_rd("t6_old", 1, 0, 32'h0, 1'b0);
        next_cycle();
        expect_rd("t6_new", 1, 0, 32'h44, 1'b0);
        next_cycle();
        b_issue_en = 1'b1; b_issue_addr = 5'd13; b_rd(1, 5'd13);
        expect_rd("t6_issue_cyc", 1, 1, 32'h0, 1'b0);
        next_cycle();
        expect_rd("t6_busy", 1, 1, 32'h0, 1'b1);
        next_cycle();
        b_wr(1, 5'd13, 32'h5);
        expect_rd("t6_wr_nobyp", 1, 1, 32'h0, 1'b1);
        next_cycle();
        expect_rd("t6_after", 1, 1, 32'h5, 1'b0);

        next_cycle();
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
